// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bundle: hazard/memory status in, register enables and flushes out.
// The slave modport is the controller's view; master is the pipeline datapath's view.
interface pipe_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;

  logic             MEM_RD;
  logic             MEM_WR;
  logic             mem_ack;
  logic             ld_exe;
  logic [REG_W-1:0] rt_exe;
  logic [REG_W-1:0] rs_id;
  logic [REG_W-1:0] rt_id;
  logic             branch_taken;

  logic             enablePC;
  logic             enableIF;
  logic             enableID;
  logic             enableEX;
  logic             enableMEM;
  logic             resetIF;
  logic             resetID;
  logic             mem_req;
  logic             mem_err;

  modport master (
    output MEM_RD, MEM_WR, mem_ack, ld_exe, rt_exe, rs_id, rt_id, branch_taken,
    input  enablePC, enableIF, enableID, enableEX, enableMEM,
    input  resetIF, resetID, mem_req, mem_err
  );

  modport slave (
    input  MEM_RD, MEM_WR, mem_ack, ld_exe, rt_exe, rs_id, rt_id, branch_taken,
    output enablePC, enableIF, enableID, enableEX, enableMEM,
    output resetIF, resetID, mem_req, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: data-memory wait freeze with timeout,
// load-use bubble insertion and taken-branch IF flush.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic               reloj,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned EN_W  = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              err_q;

  logic              acc;
  logic              freeze;
  logic              load_use;

  // Enables ordered {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
  logic [EN_W-1:0]   en;
  logic              flush_if;
  logic              flush_id;
  logic              req;

  assign acc      = bus.MEM_RD | bus.MEM_WR;
  assign freeze   = acc & ~bus.mem_ack & (state_q != ERR);
  // Register 0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = bus.ld_exe
                  & (bus.rt_exe != '0)
                  & ((bus.rt_exe == bus.rs_id) | (bus.rt_exe == bus.rt_id));

  // State register, wait counter and sticky error flag
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | (state_d == ERR);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_W'(MEM_TIMEOUT)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode; priority freeze > load-use > branch
  always_comb begin
    en       = '0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    req      = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN, MEM_WAIT: begin
          req = acc;
          if (freeze) begin
            en = '0;
          end else if (load_use) begin
            en       = EN_W'(5'b00111);
            flush_id = 1'b1;
          end else if (bus.branch_taken) begin
            en       = '1;
            flush_if = 1'b1;
          end else begin
            en = '1;
          end
        end
        default: begin
          en  = '0;
          req = 1'b0;
        end
      endcase
    end
  end

  assign bus.enablePC  = en[4];
  assign bus.enableIF  = en[3];
  assign bus.enableID  = en[2];
  assign bus.enableEX  = en[1];
  assign bus.enableMEM = en[0];
  assign bus.resetIF   = flush_if;
  assign bus.resetID   = flush_id;
  assign bus.mem_req   = req;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed wait/timeout/reset
// sequences, and randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TMO = 8;
  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ERR  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .reloj (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pipeline mode plus number of cycles spent waiting for memory
  int m_mode;
  int m_waited;

  // Output vector: {enPC, enIF, enID, enEX, enMEM, resetIF, resetID, mem_req, mem_err}
  typedef struct {
    string      name;
    logic       rd, wr, ack, ld;
    logic [4:0] rte, rs, rt;
    logic       br;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [8:0] actual();
    return {bus.enablePC, bus.enableIF, bus.enableID, bus.enableEX, bus.enableMEM,
            bus.resetIF, bus.resetID, bus.mem_req, bus.mem_err};
  endfunction

  function automatic logic [8:0] model_out();
    logic acc, stall, hazard;
    if (rst) return 9'b0;
    if (m_mode == M_ERR) return 9'b000000001;
    acc    = bus.MEM_RD | bus.MEM_WR;
    stall  = acc & ~bus.mem_ack;
    hazard = bus.ld_exe && (bus.rt_exe != 0) &&
             (bus.rt_exe == bus.rs_id || bus.rt_exe == bus.rt_id);
    if (stall)                 return {5'b00000, 2'b00, acc, 1'b0};
    else if (hazard)           return {5'b00111, 2'b01, acc, 1'b0};
    else if (bus.branch_taken) return {5'b11111, 2'b10, acc, 1'b0};
    else                       return {5'b11111, 2'b00, acc, 1'b0};
  endfunction

  task automatic model_reset();
    m_mode   = M_RUN;
    m_waited = 0;
  endtask

  task automatic model_step();
    logic stall;
    stall = (bus.MEM_RD | bus.MEM_WR) & ~bus.mem_ack;
    if (rst) begin
      model_reset();
    end else if (m_mode == M_RUN) begin
      if (stall) begin
        m_mode   = M_WAIT;
        m_waited = 1;
      end
    end else if (m_mode == M_WAIT) begin
      if (bus.mem_ack)            model_reset();
      else if (m_waited >= TMO)   m_mode = M_ERR;
      else                        m_waited++;
    end
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic ack, input logic ld,
                       input logic [4:0] rte, input logic [4:0] rs, input logic [4:0] rt,
                       input logic br);
    bus.MEM_RD = rd; bus.MEM_WR = wr; bus.mem_ack = ack; bus.ld_exe = ld;
    bus.rt_exe = rte; bus.rs_id = rs; bus.rt_id = rt; bus.branch_taken = br;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Advance one clock; inputs change and reset deasserts 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  // From RUN, hold an unacknowledged load: 1 RUN cycle + MEM_TIMEOUT wait cycles, then ERR
  task automatic timeout_run(input string tag);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k <= int'(TMO); k++) begin
      #3 check({tag, "_wait"}, actual(), 9'b000000010);
      tick();
    end
    #3 check({tag, "_err"}, actual(), 9'b000000001);
    tick();
  endtask

  initial begin
    tbl[0] = '{"idle",        0,0,0,0, 5'd0, 5'd0, 5'd0, 0, 9'b111110000};
    tbl[1] = '{"rd_ack",      1,0,1,0, 5'd0, 5'd0, 5'd0, 0, 9'b111110010};
    tbl[2] = '{"lu_rs_br",    0,0,0,1, 5'd5, 5'd5, 5'd0, 1, 9'b001110100};
    tbl[3] = '{"lu_rt",       0,0,0,1, 5'd7, 5'd1, 5'd7, 0, 9'b001110100};
    tbl[4] = '{"lu_r0",       0,0,0,1, 5'd0, 5'd0, 5'd0, 0, 9'b111110000};
    tbl[5] = '{"branch",      0,0,0,0, 5'd0, 5'd3, 5'd4, 1, 9'b111111000};
    tbl[6] = '{"frz_over_lu", 0,1,0,1, 5'd9, 5'd9, 5'd9, 1, 9'b000000010};
    tbl[7] = '{"no_load",     0,0,0,0, 5'd5, 5'd5, 5'd5, 0, 9'b111110000};
    tbl[8] = '{"ld_miss_br",  0,0,0,1, 5'd3, 5'd4, 5'd2, 1, 9'b111111000};
    tbl[9] = '{"ack_lu",      1,0,1,1, 5'd31,5'd0, 5'd31,0, 9'b001110110};

    // Reset holds every output low whatever the inputs do
    rst = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1);
    #3 check("reset_out", actual(), 9'b0);
    tick();
    #3 check("reset_hold", actual(), 9'b0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_reset();
      drive(tbl[i].rd, tbl[i].wr, tbl[i].ack, tbl[i].ld,
            tbl[i].rte, tbl[i].rs, tbl[i].rt, tbl[i].br);
      #3 check(tbl[i].name, actual(), tbl[i].exp);
      tick();
    end

    // Branch flush lasts only the cycle it is requested
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    #3 check("br_flush", actual(), 9'b111111000);
    tick();
    drive_idle();
    #3 check("br_after", actual(), 9'b111110000);
    tick();

    // Store waits three cycles, completes on the fourth, counter restarts afterwards
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #3 check("wr_stall", actual(), 9'b000000010);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #3 check("wr_ack", actual(), 9'b111110010);
    tick();
    drive_idle();
    #3 check("wr_done", actual(), 9'b111110000);
    tick();
    timeout_run("to1");

    // ERR is sticky regardless of later acks or hazards
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1);
      #3 check("err_sticky", actual(), 9'b000000001);
      tick();
    end

    // Asynchronous reset out of ERR
    #2 rst = 1'b1;
    model_reset();
    #1 check("rst_in_err", actual(), 9'b0);
    tick();
    rst = 1'b0;
    drive_idle();
    #3 check("err_recover", actual(), 9'b111110000);
    tick();

    // Asynchronous reset mid MEM_WAIT, then a full-length timeout proves the wait restarted
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    model_reset();
    #1 check("rst_in_wait", actual(), 9'b0);
    tick();
    rst = 1'b0;
    timeout_run("to2");
    do_reset();

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (rst) model_reset();
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      #3 check("random", actual(), model_out());
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
